tf_sweep_sequencer: RTL

- Automates transfer-function frequency sweeps on the modulation DDS block.
- Sits between the host command bus and the modulation block's command input.
- Forwards host commands when idle. During a run it issues its own amplitude/frequency commands.
- Generates settle/dwell timing so the downstream demodulator integrates only on settled points.

---
 rtl/tf_seq_pkg.sv | 56 +++++
 rtl/tf_cmd_mux.sv | 73 +++++++
 rtl/tf_sweep_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tf_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tf_seq_pkg
//  Purpose  : Shared definitions for the transfer-function sweep sequencer:
//             FSM state encodings, sequencer register offsets, downstream
//             modulation-block addresses, the command bus record and a
//             helper that recognises modulation-block addresses.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tf_seq_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SET_AMP  = 3'd1;
    localparam logic [2:0] ST_SET_FREQ = 3'd2;
    localparam logic [2:0] ST_SETTLE   = 3'd3;
    localparam logic [2:0] ST_DWELL    = 3'd4;
    localparam logic [2:0] ST_NEXT     = 3'd5;
    localparam logic [2:0] ST_RESTORE  = 3'd6;

    // Sequencer register offsets (cmd_addr[7:0] under BASE_HI)
    localparam logic [7:0] REG_START  = 8'h00;
    localparam logic [7:0] REG_STEP   = 8'h01;
    localparam logic [7:0] REG_NPTS   = 8'h02;
    localparam logic [7:0] REG_SETTLE = 8'h03;
    localparam logic [7:0] REG_DWELL  = 8'h04;
    localparam logic [7:0] REG_CHAN   = 8'h05;
    localparam logic [7:0] REG_GO     = 8'h10;
    localparam logic [7:0] REG_ABORT  = 8'h11;

    // Downstream modulation-block addresses
    localparam logic [15:0] TF_FREQ_ADDR = 16'h4000;
    localparam logic [15:0] TF_AMP_ADDR  = 16'h4100;

    // Range-shift value that switches modulation off
    localparam logic [4:0] RS_OFF = 5'd31;

    // Address high bytes owned by the modulation block
    localparam logic [7:0] TF_BLOCK_HI0 = 8'h40;
    localparam logic [7:0] TF_BLOCK_HI1 = 8'h41;

    // One command-bus beat
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] d1;
        logic [15:0] d2;
    } tf_cmd_t;

    function automatic logic is_tf_block(input logic [7:0] hi);
        return (hi == TF_BLOCK_HI0) || (hi == TF_BLOCK_HI1);
    endfunction

endpackage : tf_seq_pkg
`default_nettype wire

// File: rtl/tf_cmd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tf_cmd_mux
//  Purpose  : Registered downstream command bus. Chooses between a host
//             command and a sequencer command each cycle; the host wins a
//             collision and the sequencer is told via seq_gnt_o so it can
//             retry next cycle. Modulation-block host commands are dropped
//             while a run is active and reported on blocked_o.
//  Ports    : clk_i/rst_i      clock, async active-high reset
//             busy_i           sequencer run in progress
//             host_trig_i/host_cmd_i   host command strobe + beat
//             seq_req_i/seq_cmd_i      sequencer request + beat
//             seq_gnt_o        sequencer beat accepted this cycle
//             trig_o/cmd_o     registered downstream strobe + held beat
//             blocked_o        registered drop pulse
//  Revision : 1.0  initial release
// ============================================================================
module tf_cmd_mux
    import tf_seq_pkg::*;
#(
    parameter logic [7:0] BASE_HI = 8'h42
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    busy_i,
    input  logic    host_trig_i,
    input  tf_cmd_t host_cmd_i,
    input  logic    seq_req_i,
    input  tf_cmd_t seq_cmd_i,
    output logic    seq_gnt_o,
    output logic    trig_o,
    output tf_cmd_t cmd_o,
    output logic    blocked_o
);

    logic    w_host_reg;
    logic    w_host_tf;
    logic    w_host_fwd;
    logic    w_blocked;
    logic    trig_q;
    logic    blocked_q;
    tf_cmd_t cmd_q;

    // Sequencer-register traffic is consumed locally and never forwarded.
    assign w_host_reg = (host_cmd_i.addr[15:8] == BASE_HI);
    assign w_host_tf  = is_tf_block(host_cmd_i.addr[15:8]);
    assign w_host_fwd = host_trig_i && !w_host_reg && !(busy_i && w_host_tf);
    assign w_blocked  = host_trig_i && !w_host_reg && busy_i && w_host_tf;
    assign seq_gnt_o  = seq_req_i && !w_host_fwd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trig_q    <= 1'b0;
            blocked_q <= 1'b0;
            cmd_q     <= '0;
        end else begin
            trig_q    <= w_host_fwd || seq_gnt_o;
            blocked_q <= w_blocked;
            // Data is held between strobes.
            if (w_host_fwd) begin
                cmd_q <= host_cmd_i;
            end else if (seq_gnt_o) begin
                cmd_q <= seq_cmd_i;
            end
        end
    end

    assign trig_o    = trig_q;
    assign cmd_o     = cmd_q;
    assign blocked_o = blocked_q;

endmodule : tf_cmd_mux
`default_nettype wire

// File: rtl/tf_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tf_sweep_sequencer
//  Purpose  : Runs transfer-function frequency sweeps on the modulation DDS.
//             Idle: host commands pass through. Running: issues amplitude,
//             per-point frequency and restore commands, with settle/dwell
//             timing so the demodulator integrates only on settled points.
//  Ports    : clk_in/rst_in          clock, async active-high reset
//             cmd_*_in               host command bus
//             cmd_*_out              registered downstream command bus
//             busy_out               run in progress
//             acq_out                high during DWELL
//             point_done_out         pulse after each completed dwell
//             sweep_done_out         pulse with the normal RESTORE strobe
//             blocked_out            pulse when a host TF command is dropped
//             point_idx_out          current point index
//             pinc_cur_out           current phase increment
//  Revision : 1.0  initial release
// ============================================================================
module tf_sweep_sequencer
    import tf_seq_pkg::*;
#(
    parameter int         PINC_W  = 32,
    parameter int         CNT_W   = 32,
    parameter int         NPTS_W  = 16,
    parameter logic [7:0] BASE_HI = 8'h42
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cmd_trig_in,
    input  logic [15:0]       cmd_addr_in,
    input  logic [15:0]       cmd_data1_in,
    input  logic [15:0]       cmd_data2_in,
    output logic              cmd_trig_out,
    output logic [15:0]       cmd_addr_out,
    output logic [15:0]       cmd_data1_out,
    output logic [15:0]       cmd_data2_out,
    output logic              busy_out,
    output logic              acq_out,
    output logic              point_done_out,
    output logic              sweep_done_out,
    output logic              blocked_out,
    output logic [NPTS_W-1:0] point_idx_out,
    output logic [PINC_W-1:0] pinc_cur_out
);

    // Shadow (host-visible) registers
    logic [PINC_W-1:0] start_q;
    logic [PINC_W-1:0] step_q;
    logic [NPTS_W-1:0] npts_q;
    logic [CNT_W-1:0]  settle_q;
    logic [CNT_W-1:0]  dwell_q;
    logic [1:0]        chan_q;
    logic [4:0]        rs_q;

    // Working copies frozen at go
    logic [PINC_W-1:0] wstep_q;
    logic [NPTS_W-1:0] wnpts_q;
    logic [CNT_W-1:0]  wsettle_q;
    logic [CNT_W-1:0]  wdwell_q;
    logic [1:0]        wchan_q;
    logic [4:0]        wrs_q;

    // FSM state and datapath
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NPTS_W-1:0] idx_q, idx_d;
    logic [PINC_W-1:0] pinc_q, pinc_d;
    logic              aborted_q, aborted_d;
    logic              point_done_q;
    logic              sweep_done_q;

    logic              w_host_reg;
    logic [7:0]        w_off;
    logic              w_go;
    logic              w_abort;
    logic              w_pd;
    logic              w_sd;
    logic              w_seq_req;
    logic              w_seq_gnt;
    tf_cmd_t           w_seq_cmd;
    tf_cmd_t           w_host_cmd;
    tf_cmd_t           w_out_cmd;
    logic [31:0]       w_pinc32;
    logic [31:0]       w_data32;
    logic [CNT_W-1:0]  w_dwell_len;
    logic [NPTS_W-1:0] w_idx_inc;

    assign w_host_reg = cmd_trig_in && (cmd_addr_in[15:8] == BASE_HI);
    assign w_off      = cmd_addr_in[7:0];
    assign w_go       = w_host_reg && (w_off == REG_GO) && (state_q == ST_IDLE);
    assign w_abort    = w_host_reg && (w_off == REG_ABORT) && (state_q != ST_IDLE);
    assign w_data32   = {cmd_data2_in, cmd_data1_in};
    assign w_pinc32   = 32'(pinc_q);
    // A zero dwell still yields one acquisition cycle.
    assign w_dwell_len = (wdwell_q == '0) ? CNT_W'(1) : wdwell_q;
    assign w_idx_inc   = idx_q + NPTS_W'(1);

    // Shadow registers: writable at any time, including mid-run.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            start_q  <= '0;
            step_q   <= '0;
            npts_q   <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
            chan_q   <= 2'd0;
            rs_q     <= RS_OFF;
        end else if (w_host_reg) begin
            case (w_off)
                REG_START:  start_q  <= PINC_W'(w_data32);
                REG_STEP:   step_q   <= PINC_W'(w_data32);
                REG_NPTS:   npts_q   <= NPTS_W'(cmd_data1_in);
                REG_SETTLE: settle_q <= CNT_W'(w_data32);
                REG_DWELL:  dwell_q  <= CNT_W'(w_data32);
                REG_CHAN: begin
                    // Channel 3 is reserved and folds onto channel 0.
                    chan_q <= (cmd_data1_in[1:0] == 2'd3) ? 2'd0 : cmd_data1_in[1:0];
                    rs_q   <= cmd_data1_in[12:8];
                end
                default: ;
            endcase
        end
    end

    // Working copies: later shadow writes only affect the next run.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wstep_q   <= '0;
            wnpts_q   <= '0;
            wsettle_q <= '0;
            wdwell_q  <= '0;
            wchan_q   <= 2'd0;
            wrs_q     <= RS_OFF;
        end else if (w_go) begin
            wstep_q   <= step_q;
            wnpts_q   <= npts_q;
            wsettle_q <= settle_q;
            wdwell_q  <= dwell_q;
            wchan_q   <= chan_q;
            wrs_q     <= rs_q;
        end
    end

    // Sequencer command request for the issuing states.
    always_comb begin
        w_seq_req = 1'b0;
        w_seq_cmd = '0;
        case (state_q)
            ST_SET_AMP: begin
                w_seq_req      = 1'b1;
                w_seq_cmd.addr = TF_AMP_ADDR | {14'd0, wchan_q};
                w_seq_cmd.d1   = {11'd0, wrs_q};
            end
            ST_SET_FREQ: begin
                w_seq_req      = 1'b1;
                w_seq_cmd.addr = TF_FREQ_ADDR;
                w_seq_cmd.d1   = w_pinc32[15:0];
                w_seq_cmd.d2   = w_pinc32[31:16];
            end
            ST_RESTORE: begin
                w_seq_req      = 1'b1;
                w_seq_cmd.addr = TF_AMP_ADDR | {14'd0, wchan_q};
                w_seq_cmd.d1   = {11'd0, RS_OFF};
            end
            default: ;
        endcase
        // An abort diverts to RESTORE; the pending SET_* beat must not go out.
        if (w_abort && (state_q != ST_RESTORE)) begin
            w_seq_req = 1'b0;
        end
    end

    // Next-state logic. Issuing states hold until the mux grants them.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pinc_d    = pinc_q;
        aborted_d = aborted_q;
        w_pd      = 1'b0;
        w_sd      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_go) begin
                    state_d   = ST_SET_AMP;
                    idx_d     = '0;
                    pinc_d    = start_q;
                    aborted_d = 1'b0;
                end
            end
            ST_SET_AMP: begin
                if (w_seq_gnt) begin
                    state_d = (wnpts_q == '0) ? ST_RESTORE : ST_SET_FREQ;
                end
            end
            ST_SET_FREQ: begin
                if (w_seq_gnt) begin
                    if (wsettle_q == '0) begin
                        state_d = ST_DWELL;
                        cnt_d   = w_dwell_len;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = wsettle_q;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DWELL;
                    cnt_d   = w_dwell_len;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DWELL: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_NEXT;
                    w_pd    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_NEXT: begin
                idx_d   = w_idx_inc;
                pinc_d  = pinc_q + wstep_q;
                state_d = (w_idx_inc == wnpts_q) ? ST_RESTORE : ST_SET_FREQ;
            end
            ST_RESTORE: begin
                if (w_seq_gnt) begin
                    state_d = ST_IDLE;
                    w_sd    = !aborted_q && !w_abort;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_abort) begin
            aborted_d = 1'b1;
            if (state_q != ST_RESTORE) begin
                state_d = ST_RESTORE;
                w_pd    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pinc_q       <= '0;
            aborted_q    <= 1'b0;
            point_done_q <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pinc_q       <= pinc_d;
            aborted_q    <= aborted_d;
            point_done_q <= w_pd;
            // Registered alongside the bus so it coincides with the RESTORE strobe.
            sweep_done_q <= w_sd;
        end
    end

    assign w_host_cmd = '{addr: cmd_addr_in, d1: cmd_data1_in, d2: cmd_data2_in};

    tf_cmd_mux #(
        .BASE_HI (BASE_HI)
    ) u_mux (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .busy_i      (busy_out),
        .host_trig_i (cmd_trig_in),
        .host_cmd_i  (w_host_cmd),
        .seq_req_i   (w_seq_req),
        .seq_cmd_i   (w_seq_cmd),
        .seq_gnt_o   (w_seq_gnt),
        .trig_o      (cmd_trig_out),
        .cmd_o       (w_out_cmd),
        .blocked_o   (blocked_out)
    );

    assign cmd_addr_out   = w_out_cmd.addr;
    assign cmd_data1_out  = w_out_cmd.d1;
    assign cmd_data2_out  = w_out_cmd.d2;
    assign busy_out       = (state_q != ST_IDLE);
    assign acq_out        = (state_q == ST_DWELL);
    assign point_done_out = point_done_q;
    assign sweep_done_out = sweep_done_q;
    assign point_idx_out  = idx_q;
    assign pinc_cur_out   = pinc_q;

endmodule : tf_sweep_sequencer
`default_nettype wire
